// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type, default geometry and derived address-field widths
package icache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_e;
    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;
    localparam int DEF_OFF_W = $clog2(DEF_WORDS);
    localparam int DEF_IDX_W = $clog2(DEF_LINES);
    localparam int DEF_TAG_W = 30 - DEF_OFF_W - DEF_IDX_W;
endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: LINES x WORDS x 32 instruction storage, async read, one sync write port
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(LINES)-1:0] widx_i,
    input  logic [$clog2(WORDS)-1:0] wword_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(LINES)-1:0] ridx_i,
    input  logic [$clog2(WORDS)-1:0] rword_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[widx_i][wword_i] <= wdata_i;
    end

    assign rdata_o = mem_q[ridx_i][rword_i];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped I-cache with combinational lookup and req/ack line-fill FSM.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise both count ports read 0.
module icache_direct
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        ihit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    state_e           state_q, state_d;
    logic [OW-1:0]    off, beat_q, beat_d;
    logic [IW-1:0]    idx, lidx_q, lidx_d;
    logic [TW-1:0]    tag, ltag_q, ltag_d;
    logic [TW+IW-1:0] line_q, line_d;
    logic [TW-1:0]    tag_q [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic             poison_q, poison_d, lookup, we;
    logic             unused_byte_bits;

    assign unused_byte_bits = &{1'b0, pc[1:0]};
    assign off     = pc[2 +: OW];
    assign idx     = pc[2+OW +: IW];
    assign tag     = pc[31 -: TW];
    assign lookup  = valid_q[idx] && tag_q[idx] == tag;
    assign ihit    = state_q == IDLE && lookup && !flush;
    assign mem_req = state_q == FILL;
    assign mem_addr = mem_req ? {line_q, beat_q, 2'b00} : '0;

    icache_data_ram #(.LINES(LINES), .WORDS(WORDS)) u_ram (
        .clk(clk), .we_i(we), .widx_i(lidx_q), .wword_i(beat_q), .wdata_i(mem_rdata),
        .ridx_i(idx), .rword_i(off), .rdata_o(inst)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        lidx_d   = lidx_q;
        ltag_d   = ltag_q;
        line_d   = line_q;
        poison_d = poison_q;
        valid_d  = flush ? '0 : valid_q;
        we       = 1'b0;
        case (state_q)
            IDLE: if (!flush && !lookup) begin
                state_d  = FILL;
                line_d   = pc[31:2+OW];
                lidx_d   = idx;
                ltag_d   = tag;
                beat_d   = '0;
                poison_d = 1'b0;
            end
            FILL: begin
                if (flush) poison_d = 1'b1;
                if (mem_ack) begin
                    we     = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OW'(WORDS - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // a flush seen at any point of the fill leaves the line invalid
                if (!flush && !poison_q) valid_d[lidx_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
        lidx_q   <= lidx_d;
        ltag_q   <= ltag_d;
        line_q   <= line_d;
        poison_q <= poison_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == COMMIT) tag_q[lidx_q] <= ltag_q;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ihit) hit_q <= hit_q + 1'b1;
            if (state_q == IDLE && state_d == FILL) miss_q <= miss_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed plus randomized fetches against a line-level cache model
module tb_icache_direct;
    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst, flush, mem_ack, ihit, mem_req;
    logic [31:0] pc, inst, mem_addr, mem_rdata, hit_count, miss_count;

    int          checks = 0;
    int          failures = 0;
    bit          mvalid [LINES];
    int unsigned mtag [LINES];
    int unsigned mhits, mmiss;

    icache_direct #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .inst(inst), .ihit(ihit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", t, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic chk_stats(input string t);
`ifdef ICACHE_STATS_EN
        chk({t, "_hit_count"}, hit_count, mhits);
        chk({t, "_miss_count"}, miss_count, mmiss);
`else
        chk({t, "_hit_count"}, hit_count, 32'd0);
        chk({t, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // One instruction fetch; on a miss walks the whole fill with the given wait cycles per beat.
    task automatic fetch(input logic [31:0] a, input int waits, input bit fl_en, input int fl_beat);
        int unsigned idx = (a / (4 * WORDS)) % LINES;
        int unsigned tg = a / (4 * WORDS * LINES);
        logic [31:0] base = a - a % (4 * WORDS);
        bit fl = 1'b0;
        pc = a;
        flush = 1'b0;
        if (mvalid[idx] && mtag[idx] == tg) begin
            mem_ack = 1'b0;
            #1;
            chk("hit_ihit", ihit, 1);
            chk("hit_inst", inst, mem_fn(a));
            chk("hit_req", mem_req, 0);
            tick();
            mhits++;
            return;
        end
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        #1;
        chk("miss_ihit", ihit, 0);
        chk("miss_req", mem_req, 0);
        tick();
        mmiss++;
        for (int b = 0; b < WORDS; b++) begin
            for (int k = 0; k <= waits; k++) begin
                mem_ack = (k == waits);
                mem_rdata = mem_fn(base + 32'(4 * b));
                flush = fl_en && b == fl_beat && k == 0;
                fl |= flush;
                #1;
                chk("fill_req", mem_req, 1);
                chk("fill_addr", mem_addr, base + 32'(4 * b));
                chk("fill_ihit", ihit, 0);
                tick();
            end
        end
        flush = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("commit_req", mem_req, 0);
        chk("commit_ihit", ihit, 0);
        tick();
        if (fl) model_clear();
        else begin
            mvalid[idx] = 1'b1;
            mtag[idx] = tg;
        end
        chk("post_ihit", ihit, {31'd0, !fl});
        if (!fl) chk("post_inst", inst, mem_fn(a));
    endtask

    initial begin
        rst = 1'b1;
        pc = 32'h40;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mhits = 0;
        mmiss = 0;
        model_clear();
        repeat (2) tick();
        chk("rst_ihit", ihit, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk_stats("rst");
        rst = 1'b0;

        fetch(32'h40, 0, 0, 0);
        fetch(32'h44, 0, 0, 0);
        fetch(32'h48, 0, 0, 0);
        fetch(32'h4C, 0, 0, 0);
        chk_stats("cold");

        fetch(32'h440, 0, 0, 0);
        fetch(32'h40, 0, 0, 0);
        fetch(32'h80, 2, 0, 0);
        fetch(32'hC0, 0, 1, 2);
        fetch(32'hC0, 1, 0, 0);

        pc = 32'hC4;
        flush = 1'b1;
        mem_ack = 1'b0;
        #1;
        chk("flush_ihit", ihit, 0);
        tick();
        chk("flush_nofill", mem_req, 0);
        flush = 1'b0;
        model_clear();
        fetch(32'hC4, 0, 0, 0);

        for (int n = 0; n < 300; n++)
            fetch($urandom_range(0, 4095) & ~32'd3, $urandom_range(0, 2), ($urandom % 8) == 0,
                  $urandom_range(0, WORDS - 1));
        chk_stats("rand");

        fetch(32'h900, 0, 0, 0);
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        model_clear();
        pc = 32'h900;
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1;
        mem_rdata = mem_fn(32'h900);
        #1;
        chk("rmid_addr0", mem_addr, 32'h900);
        tick();
        rst = 1'b1;
        mem_rdata = mem_fn(32'h904);
        #1;
        chk("rmid_addr1", mem_addr, 32'h904);
        tick();
        rst = 1'b0;
        mhits = 0;
        mmiss = 0;
        chk("rmid_req", mem_req, 0);
        chk("rmid_addr", mem_addr, 0);
        chk("rmid_ihit", ihit, 0);
        chk_stats("rmid");
        fetch(32'h900, 1, 0, 0);
        fetch(32'h904, 0, 0, 0);
        fetch(32'h908, 0, 0, 0);
        fetch(32'h90C, 0, 0, 0);
        chk_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
